// File: rtl/shift_frame_rx.sv
// shift_frame_rx: serial-to-parallel frame receiver for the nibble-serial link.
// Samples sin on sin_en strobes, checks start/stop framing, assembles WIDTH
// data bits and presents the word on a one-entry valid/ready buffer.
// Optional build macro SHIFT_FRAME_RX_PARITY_EN inserts an even-parity bit
// between the data bits and the stop bit.
module shift_frame_rx #(
   parameter int WIDTH     = 4,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             clear_n,
   input  logic             sin,
   input  logic             sin_en,
   output logic [WIDTH-1:0] q,
   output logic             q_valid,
   input  logic             q_ready,
   output logic             busy,
   output logic             frame_err,
   output logic             overrun,
   input  logic             err_clr
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [WIDTH-1:0] shift_nxt;
   logic [CW-1:0]    cnt;
   logic             stop_strobe;
   logic             word_ok;
   logic             word_bad;
   logic             take;
`ifdef SHIFT_FRAME_RX_PARITY_EN
   logic             par_bad;
`endif

   // Next shift-register value and stop-bit decode for the current strobe
   always_comb begin
      shift_nxt = shreg;
      if (LSB_FIRST)
         shift_nxt = {sin, shreg[WIDTH-1:1]};
      else
         shift_nxt = {shreg[WIDTH-2:0], sin};
      stop_strobe = sin_en && (state == STOP);
`ifdef SHIFT_FRAME_RX_PARITY_EN
      word_ok = stop_strobe && sin && !par_bad;
`else
      word_ok = stop_strobe && sin;
`endif
      word_bad = stop_strobe && !word_ok;
      take     = q_valid && q_ready;
   end

   // A frame is in progress whenever the receiver has left IDLE
   assign busy = (state != IDLE);

   // Receive FSM: advances only on strobed bits
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         state <= IDLE;
         shreg <= '0;
         cnt   <= '0;
`ifdef SHIFT_FRAME_RX_PARITY_EN
         par_bad <= 1'b0;
`endif
      end else if (sin_en) begin
         case (state)
            IDLE: begin
               if (!sin) begin
                  state <= DATA;
                  cnt   <= '0;
               end
            end
            DATA: begin
               shreg <= shift_nxt;
               cnt   <= cnt + CW'(1);
               if (cnt == CW'(WIDTH - 1)) begin
`ifdef SHIFT_FRAME_RX_PARITY_EN
                  state <= PARITY;
`else
                  state <= STOP;
`endif
               end
            end
`ifdef SHIFT_FRAME_RX_PARITY_EN
            PARITY: begin
               // Even parity: data bits plus parity bit must XOR to zero.
               // The verdict is held until the stop bit so the stop is still consumed.
               par_bad <= ^{shreg, sin};
               state   <= STOP;
            end
`endif
            STOP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Output buffer, handshake and sticky error flags
   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         q         <= '0;
         q_valid   <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (word_ok) begin
            // Accept when empty, or when the old word leaves on this same edge
            if (!q_valid || q_ready) begin
               q       <= shreg;
               q_valid <= 1'b1;
            end
         end else if (take) begin
            q_valid <= 1'b0;
         end

         // Set events win over err_clr on the same edge
         if (word_bad)
            frame_err <= 1'b1;
         else if (err_clr)
            frame_err <= 1'b0;

         if (word_ok && q_valid && !q_ready)
            overrun <= 1'b1;
         else if (err_clr)
            overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_shift_frame_rx.sv
// Testbench for shift_frame_rx: frame table, reset abort sequence and a
// randomized run, all compared every cycle against a frame-level model.
module tb_shift_frame_rx;

   localparam int W  = 4;
   localparam bit LF = 1'b1;
`ifdef SHIFT_FRAME_RX_PARITY_EN
   localparam int FL = W + 3;
`else
   localparam int FL = W + 2;
`endif

   logic         clk = 1'b0;
   logic         clear_n = 1'b0;
   logic         sin = 1'b1;
   logic         sin_en = 1'b0;
   logic [W-1:0] q;
   logic         q_valid;
   logic         q_ready = 1'b0;
   logic         busy;
   logic         frame_err;
   logic         overrun;
   logic         err_clr = 1'b0;

   int n_total = 0;
   int n_pass  = 0;

   // Reference model state: bits of the current frame, plus output buffer
   int           bq[$];
   logic [W-1:0] mq;
   logic         mv, mfe, mov;

   typedef struct {
      logic [W-1:0] data;
      logic         stop;
      logic         pflip;
      logic         rdy;
      int           gap;
      logic [W-1:0] exp_q;
      logic         exp_v;
      logic         exp_fe;
      logic         exp_ov;
      logic         drain;
      logic         clr;
   } vec_t;

   vec_t tbl[$];

   shift_frame_rx #(.WIDTH(W), .LSB_FIRST(LF)) dut (
      .clk      (clk),
      .clear_n  (clear_n),
      .sin      (sin),
      .sin_en   (sin_en),
      .q        (q),
      .q_valid  (q_valid),
      .q_ready  (q_ready),
      .busy     (busy),
      .frame_err(frame_err),
      .overrun  (overrun),
      .err_clr  (err_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      bq.delete();
      mq  = '0;
      mv  = 1'b0;
      mfe = 1'b0;
      mov = 1'b0;
   endtask

   // Frame-level model: collect strobed bits from the start bit until the
   // frame length is reached, then judge the whole frame at once.
   task automatic model_step(input logic s, input logic en, input logic rdy, input logic clr);
      logic         done, fes, ovs, par_ok;
      logic [W-1:0] w;
      int           ones;
      done = 1'b0; fes = 1'b0; ovs = 1'b0; par_ok = 1'b1; w = '0; ones = 0;
      if (en) begin
         if (bq.size() == 0) begin
            if (!s) bq.push_back(0);
         end else begin
            bq.push_back(s ? 1 : 0);
         end
         if (bq.size() == FL) begin
            for (int i = 0; i < W; i++) begin
               if (LF) w[i] = (bq[1+i] != 0);
               else    w[W-1-i] = (bq[1+i] != 0);
               ones += bq[1+i];
            end
`ifdef SHIFT_FRAME_RX_PARITY_EN
            ones += bq[W+1];
            par_ok = (ones % 2) == 0;
`endif
            if (bq[FL-1] == 1 && par_ok) done = 1'b1;
            else fes = 1'b1;
            bq.delete();
         end
      end
      if (done) begin
         if (!mv || rdy) begin
            mq = w;
            mv = 1'b1;
         end else begin
            ovs = 1'b1;
         end
      end else if (mv && rdy) begin
         mv = 1'b0;
      end
      if (fes) mfe = 1'b1; else if (clr) mfe = 1'b0;
      if (ovs) mov = 1'b1; else if (clr) mov = 1'b0;
   endtask

   task automatic cmp_model();
      chk("q", int'(q), int'(mq));
      chk("q_valid", int'(q_valid), int'(mv));
      chk("busy", int'(busy), (bq.size() != 0) ? 1 : 0);
      chk("frame_err", int'(frame_err), int'(mfe));
      chk("overrun", int'(overrun), int'(mov));
   endtask

   // One clock with the given inputs; model follows the same edge
   task automatic cyc(input logic s, input logic en, input logic rdy, input logic clr);
      sin = s; sin_en = en; q_ready = rdy; err_clr = clr;
      @(posedge clk);
      model_step(s, en, rdy, clr);
      #1;
      cmp_model();
   endtask

   task automatic send_frame(input logic [W-1:0] d, input logic stop, input logic pflip,
                             input logic rdy, input int gap);
      int bits[$];
      bits.push_back(0);
      for (int i = 0; i < W; i++) bits.push_back((LF ? d[i] : d[W-1-i]) ? 1 : 0);
`ifdef SHIFT_FRAME_RX_PARITY_EN
      bits.push_back(((^d) ^ pflip) ? 1 : 0);
`endif
      bits.push_back(stop ? 1 : 0);
      for (int k = 0; k < bits.size(); k++) begin
         for (int g = 0; g < gap; g++) cyc(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
         cyc(bits[k] != 0, 1'b1, (k == bits.size() - 1) ? rdy : 1'b0, 1'b0);
      end
   endtask

   function automatic vec_t mk(input logic [W-1:0] d, input logic st, input logic pf,
                               input logic rdy, input int gap, input logic [W-1:0] eq,
                               input logic ev, input logic efe, input logic eov,
                               input logic dr, input logic cl);
      vec_t v;
      v.data = d; v.stop = st; v.pflip = pf; v.rdy = rdy; v.gap = gap;
      v.exp_q = eq; v.exp_v = ev; v.exp_fe = efe; v.exp_ov = eov;
      v.drain = dr; v.clr = cl;
      return v;
   endfunction

   initial begin
      tbl.push_back(mk(4'b1010, 1, 0, 0, 0, 4'b1010, 1, 0, 0, 1, 0)); // basic
      tbl.push_back(mk(4'b1010, 1, 0, 0, 2, 4'b1010, 1, 0, 0, 1, 0)); // gapped strobes
      tbl.push_back(mk(4'b0101, 0, 0, 0, 1, 4'b1010, 0, 1, 0, 0, 1)); // bad stop
      tbl.push_back(mk(4'b0011, 1, 0, 0, 0, 4'b0011, 1, 0, 0, 0, 0)); // fill buffer
      tbl.push_back(mk(4'b1100, 1, 0, 0, 0, 4'b0011, 1, 0, 1, 0, 0)); // overrun
      tbl.push_back(mk(4'b1111, 1, 0, 1, 0, 4'b1111, 1, 0, 1, 1, 1)); // ready on stop edge
`ifdef SHIFT_FRAME_RX_PARITY_EN
      tbl.push_back(mk(4'b1010, 1, 0, 0, 0, 4'b1010, 1, 0, 0, 1, 0)); // parity good
      tbl.push_back(mk(4'b1010, 1, 1, 0, 0, 4'b1010, 0, 1, 0, 0, 1)); // parity bad
`endif

      // Reset state
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      cmp_model();
      @(negedge clk);
      clear_n = 1'b1;
      cyc(1'b1, 1'b1, 1'b0, 1'b0);

      // Abort a frame after two data bits with an asynchronous reset
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      chk("busy_mid_frame", int'(busy), 1);
      #2;
      clear_n = 1'b0;
      #1;
      model_reset();
      cmp_model();
      @(negedge clk);
      clear_n = 1'b1;
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      chk("no_word_after_abort", int'(q_valid), 0);

      // Table-driven frames
      foreach (tbl[i]) begin
         send_frame(tbl[i].data, tbl[i].stop, tbl[i].pflip, tbl[i].rdy, tbl[i].gap);
         chk($sformatf("tbl%0d_q", i), int'(q), int'(tbl[i].exp_q));
         chk($sformatf("tbl%0d_valid", i), int'(q_valid), int'(tbl[i].exp_v));
         chk($sformatf("tbl%0d_ferr", i), int'(frame_err), int'(tbl[i].exp_fe));
         chk($sformatf("tbl%0d_ovr", i), int'(overrun), int'(tbl[i].exp_ov));
         if (tbl[i].clr) begin
            cyc(1'b1, 1'b0, 1'b0, 1'b1);
            chk($sformatf("tbl%0d_clr_ferr", i), int'(frame_err), 0);
            chk($sformatf("tbl%0d_clr_ovr", i), int'(overrun), 0);
         end
         if (tbl[i].drain) begin
            cyc(1'b1, 1'b0, 1'b1, 1'b0);
            chk($sformatf("tbl%0d_drain", i), int'(q_valid), 0);
            chk($sformatf("tbl%0d_q_hold", i), int'(q), int'(tbl[i].exp_q));
         end
      end

      // Randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
